// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh edge-feed sequencer.
// Holds the feed FSM state type, the width constants of the edge interfaces
// and the helper that builds the one-hot per-row skew code.
package mesh_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    STREAM,
    DRAIN,
    PAIR,
    FIN
  } feed_state_t;

  localparam int SKEW_W = 4;
  localparam int DATA_W = 32;
  localparam int CFG_W  = 64;

  // One-hot delay selector: row r is held back r cycles so the wavefront
  // enters the mesh diagonally.
  function automatic logic [SKEW_W-1:0] skew_code(input int r);
    return 4'b0001 << r;
  endfunction

endpackage

// File: rtl/mesh_feed_controller_if.sv
// Bundle of the job handshake, the broadcast to the edge interfaces and the
// per-edge done flags.
//   slave  : the feed controller (accepts jobs, drives iface_*, busy, done)
//   master : host queue plus edge interfaces (offers jobs, returns done flags)
interface mesh_feed_controller_if #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int CFG_W  = 64
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_systolic;
  logic                  req_dir;
  logic [CFG_W-1:0]      req_cfg;
  logic                  iface_reset;
  logic                  iface_load;
  logic                  iface_systolic;
  logic                  iface_dir;
  logic [CFG_W-1:0]      iface_cfg;
  logic [4*N_ROWS-1:0]   iface_delay;
  logic [N_ROWS-1:0]     west_done;
  logic [N_COLS-1:0]     north_done;
  logic                  busy;
  logic                  done;

  modport slave (
    input  req_valid, req_systolic, req_dir, req_cfg, west_done, north_done,
    output req_ready, iface_reset, iface_load, iface_systolic, iface_dir,
           iface_cfg, iface_delay, busy, done
  );

  modport master (
    output req_valid, req_systolic, req_dir, req_cfg, west_done, north_done,
    input  req_ready, iface_reset, iface_load, iface_systolic, iface_dir,
           iface_cfg, iface_delay, busy, done
  );

endinterface

// File: rtl/mesh_feed_controller_counter.sv
// feed_counter: cycle counter shared by the STREAM and DRAIN phases.
//   clk, reset : clock and synchronous active-high reset
//   clear      : return to zero on the next edge (takes priority over enable)
//   enable     : count up by one per cycle
//   limit      : runtime terminal value
//   last       : high while enabled and the count equals limit
module feed_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign last = enable && (count_reg == limit);

endmodule

// File: rtl/mesh_feed_controller.sv
// mesh_feed_controller: sequences the west/north edge interfaces of the
// systolic mesh for one job at a time.
//   clk, reset : clock and synchronous active-high reset
//   bus        : job handshake (req_*), broadcast to interfaces (iface_*),
//                per-edge done flags, busy level and one-cycle done pulse
// Job flow: IDLE -> CLEAR -> LOAD -> (STREAM -> DRAIN | PAIR) -> FIN -> IDLE.
// N_ROWS must stay within 1..4 because each row's skew code is 4 bits wide.
module mesh_feed_controller
  import mesh_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int DEPTH  = 4,
  parameter int CFG_W  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  mesh_feed_controller_if.slave bus
);

  // Stream length including the skew of the last row, and the time for the
  // last injected word to cross the mesh.
  localparam int S      = DEPTH + N_ROWS - 1;
  localparam int R      = N_ROWS + N_COLS - 1;
  localparam int MAX_SR = (S > R) ? S : R;
  localparam int CNT_W  = $clog2(MAX_SR) + 1;

  feed_state_t state_reg, state_next;

  logic [CNT_W-1:0]           cnt_limit;
  logic                       cnt_clear;
  logic                       cnt_enable;
  logic                       cnt_last;
  logic                       group_done;
  logic                       accept;

  logic                       req_ready_reg;
  logic                       busy_reg;
  logic                       done_reg;
  logic                       iface_reset_reg;
  logic                       iface_load_reg;
  logic                       iface_systolic_reg;
  logic                       iface_dir_reg;
  logic [CFG_W-1:0]           iface_cfg_reg;
  logic [SKEW_W*N_ROWS-1:0]   iface_delay_reg;
  logic [SKEW_W*N_ROWS-1:0]   delay_code;

  generate
    for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_skew
      assign delay_code[gi*SKEW_W +: SKEW_W] = skew_code(gi);
    end
  endgenerate

  assign accept = (state_reg == IDLE) && bus.req_valid;

  // Only the group selected by the latched direction counts; the other
  // group's flags are irrelevant to a direct load.
  assign group_done = iface_dir_reg ? (&bus.west_done) : (&bus.north_done);

  feed_counter #(.W(CNT_W)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (cnt_limit),
    .last   (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_enable = 1'b0;
    cnt_limit  = '0;
    case (state_reg)
      IDLE:   if (bus.req_valid) state_next = CLEAR;
      CLEAR:  state_next = LOAD;
      LOAD:   state_next = iface_systolic_reg ? STREAM : PAIR;
      STREAM: begin
        cnt_enable = 1'b1;
        cnt_limit  = CNT_W'(S - 1);
        if (cnt_last) state_next = DRAIN;
      end
      DRAIN: begin
        cnt_enable = 1'b1;
        cnt_limit  = CNT_W'(R - 1);
        if (cnt_last) state_next = FIN;
      end
      PAIR:   if (group_done) state_next = FIN;
      FIN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every state change restarts the shared counter so each phase counts from 0.
  assign cnt_clear = (state_next != state_reg);

  // Outputs are registered from the next state so they line up exactly with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_reg      <= 1'b1;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      iface_reset_reg    <= 1'b0;
      iface_load_reg     <= 1'b0;
      iface_systolic_reg <= 1'b0;
      iface_dir_reg      <= 1'b0;
      iface_cfg_reg      <= '0;
      iface_delay_reg    <= '0;
    end else begin
      req_ready_reg   <= (state_next == IDLE);
      busy_reg        <= (state_next != IDLE);
      done_reg        <= (state_next == FIN);
      iface_reset_reg <= (state_next == CLEAR);
      iface_load_reg  <= (state_next == LOAD);
      if (accept) begin
        iface_systolic_reg <= bus.req_systolic;
        iface_dir_reg      <= bus.req_dir;
        iface_cfg_reg      <= bus.req_cfg;
      end
      if (state_next == LOAD) begin
        iface_delay_reg <= delay_code;
      end
    end
  end

  assign bus.req_ready      = req_ready_reg;
  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
  assign bus.iface_reset    = iface_reset_reg;
  assign bus.iface_load     = iface_load_reg;
  assign bus.iface_systolic = iface_systolic_reg;
  assign bus.iface_dir      = iface_dir_reg;
  assign bus.iface_cfg      = iface_cfg_reg;
  assign bus.iface_delay    = iface_delay_reg;

endmodule

// File: tb/tb_mesh_feed_controller.sv
module tb_mesh_feed_controller;

  localparam int S0 = 4 + 4 - 1;
  localparam int R0 = 4 + 4 - 1;
  localparam int S1 = 6 + 2 - 1;
  localparam int R1 = 2 + 3 - 1;

  logic clk;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  mesh_feed_controller_if #(.N_ROWS(4), .N_COLS(4), .CFG_W(64)) bus0 ();
  mesh_feed_controller_if #(.N_ROWS(2), .N_COLS(3), .CFG_W(64)) bus1 ();

  mesh_feed_controller #(.N_ROWS(4), .N_COLS(4), .DEPTH(4), .CFG_W(64)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  mesh_feed_controller #(.N_ROWS(2), .N_COLS(3), .DEPTH(6), .CFG_W(64)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row r of the skew field is the one-hot value 1<<r placed at bit 4r,
  // i.e. a single set bit at position 5r.
  function automatic logic [63:0] exp_delay(input int rows);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < rows; r++) v[5*r] = 1'b1;
    return v;
  endfunction

  task automatic check_idle0(input string tag);
    check({tag, "_ready"}, bus0.req_ready, 1);
    check({tag, "_busy"}, bus0.busy, 0);
    check({tag, "_done"}, bus0.done, 0);
    check({tag, "_ireset"}, bus0.iface_reset, 0);
    check({tag, "_iload"}, bus0.iface_load, 0);
  endtask

  task automatic check_reset_vals0(input string tag);
    check_idle0(tag);
    check({tag, "_isys"}, bus0.iface_systolic, 0);
    check({tag, "_idir"}, bus0.iface_dir, 0);
    check({tag, "_icfg"}, bus0.iface_cfg, 0);
    check({tag, "_idelay"}, bus0.iface_delay, 0);
  endtask

  // Runs one job on dut0 starting at a negedge; returns at the negedge of the
  // cycle after done. k = PAIR cycle in which the selected group becomes all-done.
  task automatic do_job(input bit sys, input bit dir, input logic [63:0] cfg,
                        input int k, input bit stale, input bit oth_all,
                        input bit hold, output int t_acc, output int t_done);
    int w;
    int exp_i;
    bus0.req_valid    = 1'b1;
    bus0.req_systolic = sys;
    bus0.req_dir      = dir;
    bus0.req_cfg      = cfg;
    w = 0;
    while (!bus0.req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", bus0.req_ready, 1);
    t_acc = cyc;
    exp_i = sys ? (3 + S0 + R0) : (4 + k);
    @(negedge clk);
    if (!hold) begin
      bus0.req_valid    = 1'b0;
      bus0.req_systolic = 1'($urandom);
      bus0.req_dir      = 1'($urandom);
      bus0.req_cfg      = {$urandom, $urandom};
    end
    for (int i = 1; i <= exp_i; i++) begin
      begin
        logic [3:0] sel;
        logic [3:0] oth;
        if (i < 3)            sel = stale ? 4'hF : 4'h0;
        else if (i - 3 >= k)  sel = 4'hF;
        else                  sel = 4'($urandom_range(0, 14));
        oth = oth_all ? 4'hF : 4'($urandom);
        if (sys) begin
          bus0.west_done  = 4'($urandom);
          bus0.north_done = 4'($urandom);
        end else if (dir) begin
          bus0.west_done  = sel;
          bus0.north_done = oth;
        end else begin
          bus0.north_done = sel;
          bus0.west_done  = oth;
        end
      end
      check("job_busy", bus0.busy, 1);
      check("job_ready_low", bus0.req_ready, 0);
      check("job_done", bus0.done, (i == exp_i));
      check("job_ireset", bus0.iface_reset, (i == 1));
      check("job_iload", bus0.iface_load, (i == 2));
      if (i >= 2) begin
        check("job_icfg", bus0.iface_cfg, cfg);
        check("job_isys", bus0.iface_systolic, sys);
        check("job_idir", bus0.iface_dir, dir);
        check("job_idelay", bus0.iface_delay, exp_delay(4));
      end
      if (i < exp_i) @(negedge clk);
    end
    t_done = cyc;
    check("job_latency", t_done - t_acc, exp_i);
    @(negedge clk);
    check("after_done_pulse", bus0.done, 0);
    check("after_busy", bus0.busy, 0);
    check("after_ready", bus0.req_ready, 1);
    $display("job sys=%0d dir=%0d cfg=%h accepted=%0d done=%0d latency=%0d",
             sys, dir, cfg, t_acc, t_done, t_done - t_acc);
  endtask

  initial begin
    int ta, td, ta2, td2, w, gap;
    logic [63:0] cfg;

    reset = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_systolic = 1'b0; bus0.req_dir = 1'b0;
    bus0.req_cfg = '0; bus0.west_done = '0; bus0.north_done = '0;
    bus1.req_valid = 1'b0; bus1.req_systolic = 1'b0; bus1.req_dir = 1'b0;
    bus1.req_cfg = '0; bus1.west_done = '0; bus1.north_done = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle period after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_vals0("idle");
    end
    check("idle1_ready", bus1.req_ready, 1);
    check("idle1_busy", bus1.busy, 0);

    // Directed systolic job with default geometry.
    do_job(1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567, 0, 1'b0, 1'b0, 1'b0, ta, td);
    check("sys_done_T17", td - ta, 17);

    // Direct west job: north all-done is ignored, west rises 5 cycles into PAIR.
    do_job(1'b0, 1'b1, {$urandom, $urandom}, 5, 1'b0, 1'b1, 1'b0, ta, td);
    check("dir_done_T9", td - ta, 9);

    // Minimum direct latency, with stale done bits during CLEAR/LOAD.
    do_job(1'b0, 1'b0, {$urandom, $urandom}, 0, 1'b1, 1'b0, 1'b0, ta, td);
    check("dir_min_T4", td - ta, 4);

    // Request held across two jobs.
    cfg = {$urandom, $urandom};
    do_job(1'b1, 1'b0, cfg, 0, 1'b0, 1'b0, 1'b1, ta, td);
    do_job(1'b1, 1'b0, cfg, 0, 1'b0, 1'b0, 1'b0, ta2, td2);
    check("b2b_gap", ta2 - td, 1);

    // Reset during DRAIN while req_valid is held high.
    bus0.req_valid = 1'b1; bus0.req_systolic = 1'b1; bus0.req_dir = 1'b0;
    bus0.req_cfg = {$urandom, $urandom};
    w = 0;
    while (!bus0.req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("rst_accept_wait", bus0.req_ready, 1);
    ta = cyc;
    repeat (3 + S0 + 2) @(negedge clk);
    check("rst_in_drain_busy", bus0.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals0("rst_mid");
    reset = 1'b0;
    $display("job reset-abort accepted=%0d reset_at=%0d", ta, cyc - 1);
    do_job(1'b1, 1'b0, {$urandom, $urandom}, 0, 1'b0, 1'b0, 1'b0, ta, td);
    check("post_rst_T17", td - ta, 17);

    // Randomized jobs with idle gaps.
    for (int j = 0; j < 8; j++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_idle0("gap");
      end
      do_job(1'($urandom), 1'($urandom), {$urandom, $urandom},
             $urandom_range(0, 6), 1'($urandom), 1'b0, 1'b0, ta, td);
    end

    // Second geometry: 2 rows, 3 columns, depth 6.
    bus1.req_valid = 1'b1; bus1.req_systolic = 1'b1; bus1.req_dir = 1'b0;
    cfg = {$urandom, $urandom};
    bus1.req_cfg = cfg;
    w = 0;
    while (!bus1.req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("g1_accept_wait", bus1.req_ready, 1);
    ta = cyc;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    for (int i = 1; i <= 3 + S1 + R1; i++) begin
      check("g1_busy", bus1.busy, 1);
      check("g1_done", bus1.done, (i == 3 + S1 + R1));
      if (i == 2) begin
        check("g1_idelay", bus1.iface_delay, exp_delay(2));
        check("g1_icfg", bus1.iface_cfg, cfg);
      end
      if (i < 3 + S1 + R1) @(negedge clk);
    end
    td = cyc;
    check("g1_T14", td - ta, 14);
    @(negedge clk);
    check("g1_after_done", bus1.done, 0);
    check("g1_after_ready", bus1.req_ready, 1);
    $display("job geom2 accepted=%0d done=%0d latency=%0d", ta, td, td - ta);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
